// File: rtl/mem_pkg.sv
// Shared constants and types for the main-memory arbiter slice.
// The port indices match the bit positions of the rr_arbiter2 request vector.
package mem_pkg;

  localparam int DATA_WIDTH = 128;
  localparam int ADDR_WIDTH = 25;

  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin grant: the grant is combinational, and the pointer is updated on a taken grant.
// No latency. The loser of a tie keeps its request up and wins the next arbitration.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_idx,
  output logic       any_req
);

  logic last_grant;

  always_comb begin
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
  end

  assign any_req = |req;

  // Reset to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter that shares main memory between the icache fill path (port 0) and the dcache path (port 1). It sequences CS/OE/WE against mem_ready.
// Latency is grant + issue + memory busy + done. Requests are held until ack, and a request that arrives mid-transfer waits without preempting.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH,
  parameter int Addr_Width = ADDR_WIDTH,
  parameter int Timeout    = 16,
  parameter int Tmo_Width  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [Addr_Width-1:0] addr0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [Addr_Width-1:0] addr1,
  input  logic [Data_Width-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [Data_Width-1:0] rdata,
  output logic                  err,
  output logic                  mem_cs,
  output logic                  mem_oe,
  output logic                  mem_we,
  output logic [Addr_Width-1:0] mem_addr,
  output logic [Data_Width-1:0] mem_wdata,
  input  logic [Data_Width-1:0] mem_rdata,
  input  logic                  mem_ready
);

  arb_state_t            state, next_state;
  logic                  gnt_idx, any_req, grant;
  logic                  gnt_port, we_q, tmo_hit, finish, timed_out;
  logic [Data_Width-1:0] line_q;
  logic [Tmo_Width-1:0]  tmo_cnt;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1, req0}),
    .update  (grant),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  assign grant   = (state == IDLE) && mem_ready && any_req;
  assign tmo_hit = (tmo_cnt >= Tmo_Width'(Timeout - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    finish     = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (grant) next_state = ISSUE;
      end
      ISSUE: begin
        if (!mem_ready) begin
          next_state = BUSY;
        end else if (tmo_hit) begin
          next_state = DONE;
          finish     = 1'b1;
          timed_out  = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ready || tmo_hit) begin
          next_state = DONE;
          finish     = 1'b1;
          timed_out  = ~mem_ready;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The strobe registers double as the latched address, write flag and write data of the granted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_cs    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      gnt_port  <= 1'b0;
      we_q      <= 1'b0;
      line_q    <= '0;
      tmo_cnt   <= '0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      if (grant) begin
        gnt_port  <= gnt_idx;
        we_q      <= gnt_idx & we1;
        mem_cs    <= 1'b1;
        mem_we    <= gnt_idx & we1;
        mem_oe    <= ~(gnt_idx & we1);
        mem_addr  <= gnt_idx ? addr1 : addr0;
        mem_wdata <= gnt_idx ? wdata1 : '0;
        line_q    <= '0;
        tmo_cnt   <= '0;
      end else if (state == ISSUE || state == BUSY) begin
        if (tmo_cnt != Tmo_Width'(Timeout)) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
        if (state == BUSY && !mem_ready && !we_q) begin
          line_q <= mem_rdata;
        end
        if (finish) begin
          mem_cs    <= 1'b0;
          mem_oe    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          ack0      <= (gnt_port == 1'(PORT_I));
          ack1      <= (gnt_port == 1'(PORT_D));
          err       <= timed_out;
          rdata     <= we_q ? '0 : line_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter, using a memory model with a 2-cycle busy time that triggers on the CS rising edge.
// It covers read, write, round-robin, timeout, reset mid-transfer and a request raised mid-transfer.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int DW = 128;
  localparam int AW = 25;
  localparam logic [DW-1:0] LINE_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] LINE_W = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata1;
  logic          ack0, ack1, err;
  logic [DW-1:0] rdata;
  logic          mem_cs, mem_oe, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready = 1'b1;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .addr0     (addr0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .err       (err),
    .mem_cs    (mem_cs),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: busy for two cycles after a CS rising edge, and drives read data only while CS is held and it is busy.
  logic [DW-1:0] mem_store [logic [AW-1:0]];
  logic          cs_d     = 1'b0;
  logic          mem_dead = 1'b0;
  int            busy_cnt = 0;
  logic [DW-1:0] rd_line  = '0;

  always @(posedge clk) begin
    cs_d <= mem_cs;
    if (mem_cs && !cs_d && mem_ready && !mem_dead) begin
      mem_ready <= 1'b0;
      busy_cnt  <= 1;
      if (mem_we) mem_store[mem_addr] = mem_wdata;
      else        rd_line <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : '0;
    end else if (!mem_ready) begin
      if (busy_cnt == 0) mem_ready <= 1'b1;
      else               busy_cnt  <= busy_cnt - 1;
    end
  end

  assign mem_rdata = (mem_cs && !mem_ready) ? rd_line : '0;

  // Bus monitors
  int            ack1_cnt = 0, both_cnt = 0, low_run = 0, last_gap = 0;
  logic          cs_prev = 1'b0, rise_we = 1'b0, rise_oe = 1'b0;
  logic [AW-1:0] rise_addr = '0;

  always @(negedge clk) begin
    if (ack0 && ack1) both_cnt++;
    if (ack1) ack1_cnt++;
    if (mem_cs && !cs_prev) begin
      last_gap  = low_run;
      rise_we   = mem_we;
      rise_oe   = mem_oe;
      rise_addr = mem_addr;
    end
    low_run = mem_cs ? 0 : low_run + 1;
    cs_prev = mem_cs;
  end

  int vec_cnt = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of clock edges until the port's ack is visible, or 0 if the budget runs out.
  task automatic wait_ack(input int port, output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_any(output int port);
    port = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (ack0) begin port = 0; break; end
      if (ack1) begin port = 1; break; end
    end
  endtask

  task automatic wait_busy(output int ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (dut.state == BUSY) begin ok = 1; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, p, ok, a1;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata1 = '0;
    mem_store[25'd1000] = LINE_A;
    repeat (3) step();

    check("reset strobes/acks", {ack0, ack1, err, mem_cs, mem_oe, mem_we}, 6'b0);
    check("reset rdata", rdata, '0);
    check("reset mem_addr", mem_addr, '0);
    check("reset state", dut.state, IDLE);
    reset = 1'b0;
    step();

    // Port 0 read
    addr0 = 25'd1000; req0 = 1'b1;
    wait_ack(0, n);
    check("p0 read latency", n, 5);
    check("p0 read rdata", rdata, LINE_A);
    check("p0 read err", err, 0);
    check("p0 read oe/we", {rise_oe, rise_we}, 2'b10);
    check("p0 read addr", rise_addr, 1000);
    req0 = 1'b0;
    step();
    check("p0 ack one pulse", ack0, 0);
    check("p0 no ack1", ack1_cnt, 0);

    // Port 1 write, then read back
    addr1 = 25'd10000; wdata1 = LINE_W; we1 = 1'b1; req1 = 1'b1;
    wait_ack(1, n);
    check("p1 write latency", n, 5);
    check("p1 write oe/we", {rise_oe, rise_we}, 2'b01);
    check("p1 write addr", rise_addr, 10000);
    check("p1 write rdata", rdata, '0);
    check("p1 write err", err, 0);
    we1 = 1'b0;
    wait_ack(1, n);
    check("p1 readback latency", n, 6);
    check("p1 readback rdata", rdata, LINE_W);
    check("cs low gap", (last_gap >= 1), 1);
    req1 = 1'b0;
    step();

    // Both ports requesting from reset, held: round-robin
    reset = 1'b1;
    step();
    step();
    addr0 = 25'd1000; req0 = 1'b1;
    addr1 = 25'd10000; we1 = 1'b0; req1 = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_any(p);
      check($sformatf("rr grant %0d", i), p, i % 2);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();
    check("no double ack", both_cnt, 0);

    // Memory never answers: timeout
    mem_dead = 1'b1;
    addr0 = 25'd5; req0 = 1'b1;
    wait_ack(0, n);
    check("timeout latency", n, 17);
    check("timeout err", err, 1);
    check("timeout strobes", {mem_cs, mem_oe, mem_we}, 3'b0);
    check("timeout rdata", rdata, '0);
    req0 = 1'b0; mem_dead = 1'b0;
    step();
    addr0 = 25'd1000; req0 = 1'b1;
    wait_ack(0, n);
    check("post-timeout latency", n, 5);
    check("post-timeout err", err, 0);
    check("post-timeout rdata", rdata, LINE_A);
    req0 = 1'b0;
    step();

    // Reset during BUSY of a port 1 read
    addr1 = 25'd10000; we1 = 1'b0; req1 = 1'b1;
    wait_busy(ok);
    check("reached BUSY", ok, 1);
    addr0 = 25'd1000; req0 = 1'b1;
    a1 = ack1_cnt;
    reset = 1'b1;
    step();
    check("midreset strobes/acks", {ack0, ack1, err, mem_cs, mem_oe, mem_we}, 6'b0);
    check("midreset rdata", rdata, '0);
    check("midreset mem_addr", mem_addr, '0);
    check("midreset state", dut.state, IDLE);
    reset = 1'b0;
    wait_any(p);
    check("after reset first grant", p, 0);
    check("after reset no ack1", ack1_cnt, a1);
    check("after reset p0 rdata", rdata, LINE_A);
    req0 = 1'b0;
    wait_ack(1, n);
    check("after reset p1 served", ack1, 1);
    check("after reset p1 rdata", rdata, LINE_W);
    req1 = 1'b0;
    step();

    // req1 raised while port 0 is in BUSY
    addr0 = 25'd1000; req0 = 1'b1;
    wait_busy(ok);
    check("p0 reached BUSY", ok, 1);
    a1 = ack1_cnt;
    addr1 = 25'd10000; we1 = 1'b0; req1 = 1'b1;
    wait_ack(0, n);
    check("mid p0 acked", ack0, 1);
    check("mid p1 not issued", rise_addr, 1000);
    check("mid no ack1 yet", ack1_cnt, a1);
    req0 = 1'b0;
    step();
    check("mid idle cycle cs", mem_cs, 0);
    step();
    check("mid p1 issue cs", mem_cs, 1);
    check("mid p1 issue addr", mem_addr, 10000);
    wait_ack(1, n);
    check("mid p1 rdata", rdata, LINE_W);
    req1 = 1'b0;
    step();
    check("never double ack", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
